rtc_burst_reader: RTL and testbench

Parametrised RTC read sequencer. It reads up to MAX_REGS consecutive RTC registers in one burst over the multiplexed address/data bus. Each register value is captured and written into the display/holding RAM at consecutive slots. It sits between the top-level control FSM, which issues `start`, and the RTC pins plus RAM write port, and replaces the per-field single-register read FSMs.

---
 rtl/rtc_burst_pkg.sv | 28 ++
 rtl/rtc_bus_phase.sv | 38 +++
 rtl/rtc_burst_reader.sv | 202 ++++++++++++++++++++
 tb/tb_rtc_burst_reader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rtc_burst_pkg.sv
// Shared state encoding, strobe levels and defaults for the RTC burst reader.
// Optional feature macro used by the top: RTC_BURST_ECHO_ADDR_EN.
package rtc_burst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_GAP_A,
    ST_READ,
    ST_GAP_R,
    ST_STORE,
    ST_FINISH
  } state_t;

  // RTC strobes and the address/data select all rest high
  localparam logic STROBE_IDLE = 1'b1;

  localparam int DEF_PULSE_W = 4;
  localparam int DEF_GAP_W   = 2;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/rtc_bus_phase.sv
// Bus phase timer: loaded with the strobe or gap length, flags the last cycle
// of the phase so the burst FSM can step.
module rtc_bus_phase
  import rtc_burst_pkg::*;
#(
  parameter int PULSE_W = DEF_PULSE_W,
  parameter int GAP_W   = DEF_GAP_W
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic load,
  input  logic load_gap,
  output logic phase_last
);

  localparam int LEN_MAX = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CNT_W   = clog2(LEN_MAX);
  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_W - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_gap ? GAP_LOAD : PULSE_LOAD;
    end else if (cnt_reg != '0) begin
      cnt_reg <= cnt_reg - CNT_W'(1);
    end
  end

  assign phase_last = (cnt_reg == '0);

endmodule

// File: rtl/rtc_burst_reader.sv
// Burst read sequencer: reads consecutive RTC registers over the muxed bus and
// writes them to consecutive RAM slots. Define RTC_BURST_ECHO_ADDR_EN to also store each address.
module rtc_burst_reader
  import rtc_burst_pkg::*;
#(
  parameter int MAX_REGS = 8,
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 8,
  parameter int RAM_AW   = 6,
  parameter int PULSE_W  = DEF_PULSE_W,
  parameter int GAP_W    = DEF_GAP_W
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            abort,
  input  logic [ADDR_W-1:0]               base_addr,
  input  logic [clog2(MAX_REGS+1)-1:0]    count,
  input  logic [RAM_AW-1:0]               ram_base,
  output logic                            busy,
  output logic                            done,
  output logic                            a_d,
  output logic                            cs,
  output logic                            rd,
  output logic                            wr,
  output logic [DATA_W-1:0]               ad_out,
  output logic                            ad_oe,
  input  logic [DATA_W-1:0]               ad_in,
  output logic [RAM_AW-1:0]               ram_addr,
  output logic [DATA_W-1:0]               ram_wdata,
  output logic                            ram_we
);

  localparam int CW = clog2(MAX_REGS + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_REGS);

`ifdef RTC_BURST_ECHO_ADDR_EN
  localparam bit ECHO_ADDR = 1'b1;
`else
  localparam bit ECHO_ADDR = 1'b0;
`endif

  state_t              state_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [RAM_AW-1:0]   ram_base_reg;
  logic [CW-1:0]       cnt_reg;
  logic [CW-1:0]       idx_reg;
  logic [DATA_W-1:0]   data_reg;
  logic                half_reg;
  logic                busy_reg;
  logic                done_reg;
  logic                a_d_reg;
  logic                cs_reg;
  logic                rd_reg;
  logic                wr_reg;
  logic [DATA_W-1:0]   ad_out_reg;
  logic                ad_oe_reg;

  logic [CW-1:0]       count_eff;
  logic [CW-1:0]       idx_next;
  logic                idx_last;
  logic                store_last;
  logic                aborting;
  logic                phase_clear;
  logic                phase_load;
  logic                phase_gap;
  logic                phase_last;

  assign count_eff  = (count > MAX_CNT) ? MAX_CNT : count;
  assign idx_next   = idx_reg + CW'(1);
  assign idx_last   = (idx_next >= cnt_reg);
  assign store_last = ECHO_ADDR ? half_reg : 1'b1;
  assign aborting   = abort && (state_reg != ST_IDLE);

  rtc_bus_phase #(
    .PULSE_W (PULSE_W),
    .GAP_W   (GAP_W)
  ) u_phase (
    .clk        (clk),
    .reset      (reset),
    .clear      (phase_clear),
    .load       (phase_load),
    .load_gap   (phase_gap),
    .phase_last (phase_last)
  );

  always_comb begin
    phase_clear = 1'b0;
    phase_load  = 1'b0;
    phase_gap   = 1'b0;
    if (aborting) begin
      phase_clear = 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE:  phase_load = start && !busy_reg;
        ST_ADDR:  begin phase_load = phase_last; phase_gap = 1'b1; end
        ST_GAP_A: phase_load = phase_last;
        ST_READ:  begin phase_load = phase_last; phase_gap = 1'b1; end
        ST_STORE: phase_load = store_last && !idx_last;
        default:  phase_load = 1'b0;
      endcase
    end
  end

  // Pins are registered from the current state, so they trail the FSM by one cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      addr_reg     <= '0;
      ram_base_reg <= '0;
      cnt_reg      <= '0;
      idx_reg      <= '0;
      data_reg     <= '0;
      half_reg     <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      a_d_reg      <= STROBE_IDLE;
      cs_reg       <= STROBE_IDLE;
      rd_reg       <= STROBE_IDLE;
      wr_reg       <= STROBE_IDLE;
      ad_out_reg   <= '0;
      ad_oe_reg    <= 1'b0;
    end else if (aborting) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      half_reg  <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      a_d_reg   <= STROBE_IDLE;
      cs_reg    <= STROBE_IDLE;
      rd_reg    <= STROBE_IDLE;
      wr_reg    <= STROBE_IDLE;
      ad_oe_reg <= 1'b0;
    end else begin
      busy_reg  <= (state_reg != ST_IDLE);
      done_reg  <= (state_reg == ST_FINISH);
      a_d_reg   <= (state_reg != ST_ADDR);
      cs_reg    <= !((state_reg == ST_ADDR) || (state_reg == ST_READ));
      wr_reg    <= (state_reg != ST_ADDR);
      rd_reg    <= (state_reg != ST_READ);
      ad_oe_reg <= (state_reg == ST_ADDR);
      if (state_reg == ST_ADDR) ad_out_reg <= DATA_W'(addr_reg);
      // Sampled every cycle rd is low; the last sample is the one stored
      if (!rd_reg) data_reg <= ad_in;

      case (state_reg)
        ST_IDLE: begin
          if (start && !busy_reg) begin
            addr_reg     <= base_addr;
            ram_base_reg <= ram_base;
            cnt_reg      <= count_eff;
            idx_reg      <= '0;
            half_reg     <= 1'b0;
            state_reg    <= (count_eff == '0) ? ST_FINISH : ST_ADDR;
          end
        end
        ST_ADDR:  if (phase_last) state_reg <= ST_GAP_A;
        ST_GAP_A: if (phase_last) state_reg <= ST_READ;
        ST_READ:  if (phase_last) state_reg <= ST_GAP_R;
        ST_GAP_R: if (phase_last) state_reg <= ST_STORE;
        ST_STORE: begin
          if (!store_last) begin
            half_reg <= 1'b1;
          end else begin
            half_reg  <= 1'b0;
            idx_reg   <= idx_next;
            addr_reg  <= addr_reg + ADDR_W'(1);
            state_reg <= idx_last ? ST_FINISH : ST_ADDR;
          end
        end
        ST_FINISH: state_reg <= ST_IDLE;
        default:   state_reg <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_addr  = '0;
    ram_wdata = '0;
    if (state_reg == ST_STORE) begin
      ram_we = 1'b1;
      if (ECHO_ADDR) begin
        ram_addr  = ram_base_reg + RAM_AW'({idx_reg, half_reg});
        ram_wdata = half_reg ? data_reg : DATA_W'(addr_reg);
      end else begin
        ram_addr  = ram_base_reg + RAM_AW'(idx_reg);
        ram_wdata = data_reg;
      end
    end
  end

  assign busy   = busy_reg;
  assign done   = done_reg;
  assign a_d    = a_d_reg;
  assign cs     = cs_reg;
  assign rd     = rd_reg;
  assign wr     = wr_reg;
  assign ad_out = ad_out_reg;
  assign ad_oe  = ad_oe_reg;

endmodule

// File: tb/tb_rtc_burst_reader.sv
// Scoreboard bench for rtc_burst_reader: random bursts against an arithmetic
// model of RAM writes and done timing, plus abort and mid-burst reset cases.
`timescale 1ns/1ps
module tb_rtc_burst_reader;

  localparam int MAX_REGS = 8;
  localparam int PULSE_W  = 4;
  localparam int GAP_W    = 2;
`ifdef RTC_BURST_ECHO_ADDR_EN
  localparam int ECHO = 1;
`else
  localparam int ECHO = 0;
`endif
  localparam int T_REG = 2 * PULSE_W + 2 * GAP_W + 1 + ECHO;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] base_addr = 8'h00;
  logic [3:0] count = 4'd0;
  logic [5:0] ram_base = 6'h00;
  logic       busy, done, a_d, cs, rd, wr, ad_oe, ram_we;
  logic [7:0] ad_out, ad_in, ram_wdata;
  logic [5:0] ram_addr;

  logic [7:0] rtc_addr = 8'h00;
  int         cyc = 0;
  int         n_checks = 0;
  int         n_fails = 0;
  int         last_done_cyc = -1;
  logic [13:0] wq[$];
  int          dq[$];

  rtc_burst_reader #(
    .MAX_REGS (MAX_REGS),
    .ADDR_W   (8),
    .DATA_W   (8),
    .RAM_AW   (6),
    .PULSE_W  (PULSE_W),
    .GAP_W    (GAP_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .abort     (abort),
    .base_addr (base_addr),
    .count     (count),
    .ram_base  (ram_base),
    .busy      (busy),
    .done      (done),
    .a_d       (a_d),
    .cs        (cs),
    .rd        (rd),
    .wr        (wr),
    .ad_out    (ad_out),
    .ad_oe     (ad_oe),
    .ad_in     (ad_in),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RTC model: latches the address phase, returns addr ^ 0xA5 on reads
  always @(posedge clk) if (!cs && !a_d && !wr) rtc_addr <= ad_out;
  assign ad_in = rtc_addr ^ 8'hA5;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic mon_step();
    logic [13:0] e;
    if (reset) begin
      n_checks++;
      if (cs ? !(rd && wr && a_d && !ad_oe)
             : !((!wr && rd && !a_d && ad_oe) || (!rd && wr && a_d && !ad_oe))) begin
        n_fails++;
        $display("FAIL strobes: got cs=%b rd=%b wr=%b a_d=%b oe=%b, required a legal idle/ADDR/READ set (cycle %0d)",
                 cs, rd, wr, a_d, ad_oe, cyc);
      end
    end
    if (ram_we === 1'b1) begin
      if (wq.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL ram_write: got unexpected write addr=0x%0h data=0x%0h, required none (cycle %0d)",
                 ram_addr, ram_wdata, cyc);
      end else begin
        e = wq.pop_front();
        chk("ram_addr", 32'(ram_addr), 32'(e[13:8]));
        chk("ram_wdata", 32'(ram_wdata), 32'(e[7:0]));
      end
    end
    if (done === 1'b1) begin
      last_done_cyc = cyc;
      if (dq.size() == 0) begin
        n_checks++;
        n_fails++;
        $display("FAIL done: got unexpected done pulse, required none (cycle %0d)", cyc);
      end else begin
        chk("done_cycle", 32'(cyc), 32'(dq.pop_front()));
      end
    end
  endtask

  // Reference model: expected RAM writes of a burst, straight from the address rules
  function automatic int push_expect(input logic [7:0] b, input int n, input logic [5:0] rb);
    int eff;
    eff = (n > MAX_REGS) ? MAX_REGS : n;
    for (int k = 0; k < eff; k++) begin
      logic [7:0] a;
      logic [5:0] s;
      a = b + 8'(k);
      if (ECHO != 0) begin
        s = rb + 6'(2 * k);
        wq.push_back({s, a});
        s = rb + 6'(2 * k + 1);
        wq.push_back({s, a ^ 8'hA5});
      end else begin
        s = rb + 6'(k);
        wq.push_back({s, a ^ 8'hA5});
      end
    end
    return eff;
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_ram_we"}, 32'(ram_we), 0);
    chk({tag, "_ad_oe"}, 32'(ad_oe), 0);
    chk({tag, "_a_d"}, 32'(a_d), 1);
    chk({tag, "_cs"}, 32'(cs), 1);
    chk({tag, "_rd"}, 32'(rd), 1);
    chk({tag, "_wr"}, 32'(wr), 1);
    chk({tag, "_ad_out"}, 32'(ad_out), 0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 0);
    chk({tag, "_ram_wdata"}, 32'(ram_wdata), 0);
  endtask

  task automatic run_burst(input logic [7:0] b, input int n, input logic [5:0] rb);
    int eff, e0, guard;
    step();
    base_addr = b;
    count     = 4'(n);
    ram_base  = rb;
    start     = 1'b1;
    @(posedge clk);
    #1;
    e0  = cyc;
    eff = push_expect(b, n, rb);
    dq.push_back(e0 + eff * T_REG + 1);
    $display("burst base=0x%02h count=%0d ram_base=0x%02h expected_writes=%0d done_at=%0d",
             b, n, rb, wq.size(), e0 + eff * T_REG + 1);
    chk("cs_at_accept", 32'(cs), 1);
    // start stays high and inputs change while busy; none of it may matter
    base_addr = 8'($urandom);
    count     = 4'($urandom);
    ram_base  = 6'($urandom);
    @(posedge clk);
    #1;
    chk("busy_rise", 32'(busy), 1);
    chk("cs_first_edge", 32'(cs), (eff == 0) ? 1 : 0);
    base_addr = 8'($urandom);
    ram_base  = 6'($urandom);
    @(posedge clk);
    #1;
    start = 1'b0;
    guard = 0;
    while ((dq.size() != 0 || wq.size() != 0) && guard < 1000) begin
      step();
      guard++;
    end
    if (guard >= 1000) begin
      n_checks++;
      n_fails++;
      $display("FAIL burst_timeout: got %0d writes and %0d done pending, required 0", wq.size(), dq.size());
      wq.delete();
      dq.delete();
    end
    guard = 0;
    while (busy && guard < 20) begin
      step();
      guard++;
    end
    chk("busy_fall_cycle", 32'(cyc), 32'(last_done_cyc + 1));
  endtask

  initial begin
    int falls, guard;
    logic prev_rd;
    fork
      forever begin
        @(negedge clk);
        mon_step();
      end
    join_none

    repeat (3) step();
    check_reset_values("reset");
    reset = 1'b1;
    repeat (2) step();

    run_burst(8'h21, 3, 6'h10);
    run_burst(8'h55, 0, 6'h05);
    run_burst(8'hFE, 12, 6'h3E);

    // abort during the second READ phase
    step();
    base_addr = 8'h40;
    count     = 4'd4;
    ram_base  = 6'h20;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    void'(push_expect(8'h40, 1, 6'h20));
    $display("abort burst base=0x40 count=4 ram_base=0x20 expected_writes=%0d", wq.size());
    falls   = 0;
    prev_rd = 1'b1;
    guard   = 0;
    while (falls < 2 && guard < 200) begin
      step();
      if (prev_rd && !rd) falls++;
      prev_rd = rd;
      guard++;
    end
    chk("abort_reached_read2", 32'(falls), 2);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    chk("abort_cs", 32'(cs), 1);
    chk("abort_rd", 32'(rd), 1);
    chk("abort_wr", 32'(wr), 1);
    chk("abort_ad_oe", 32'(ad_oe), 0);
    repeat (60) step();
    chk("abort_writes_left", 32'(wq.size()), 0);
    chk("abort_busy", 32'(busy), 0);
    run_burst(8'h10, 1, 6'h00);

    // asynchronous reset while the address strobe is active
    step();
    base_addr = 8'h70;
    count     = 4'd2;
    ram_base  = 6'h00;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    guard = 0;
    while (cs && guard < 20) begin
      step();
      guard++;
    end
    chk("reset_test_cs_low", 32'(cs), 0);
    #2;
    reset = 1'b0;
    #1;
    check_reset_values("async_reset");
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    reset = 1'b1;
    step();
    chk("post_reset_busy", 32'(busy), 0);

    run_burst(8'h21, 2, 6'h00);

    for (int r = 0; r < 6; r++) begin
      run_burst(8'($urandom), int'($urandom_range(0, 12)), 6'($urandom));
    end

    repeat (5) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
